// File: rtl/lsu_dmem_master.sv
// LSU-side data-memory initiator: queues load/store ops in a small FIFO, issues
// them one at a time on the dmem bus and returns one tagged response per op.
module lsu_dmem_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_is_store,
  output logic              resp_err,
  input  logic              flush,
  output logic              busy,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  logic              r_q_we    [QDEPTH];
  logic [ADDR_W-1:0] r_q_addr  [QDEPTH];
  logic [DATA_W-1:0] r_q_wdata [QDEPTH];
  logic [TAG_W-1:0]  r_q_tag   [QDEPTH];
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_suppress;
  logic [TAG_W-1:0]  r_cur_tag;
  logic              r_resp_valid, r_resp_is_store, r_resp_err;
  logic [TAG_W-1:0]  r_resp_tag;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_dmem_req, r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;

  logic [PTR_W:0]    w_count;
  logic              w_full, w_empty, w_push, w_pop, w_avail, w_done, w_issue;
  logic [PTR_W-1:0]  w_wr_idx, w_rd_idx;
  logic              w_head_we, w_head_aligned;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;
  logic [TAG_W-1:0]  w_head_tag;

  // Wrap bit in the pointers distinguishes full from empty.
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == (PTR_W+1)'(QDEPTH));
  assign w_empty  = (w_count == '0);
  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign w_push   = req_valid && !w_full;

  assign w_head_we      = r_q_we[w_rd_idx];
  assign w_head_addr    = r_q_addr[w_rd_idx];
  assign w_head_wdata   = r_q_wdata[w_rd_idx];
  assign w_head_tag     = r_q_tag[w_rd_idx];
  assign w_head_aligned = (w_head_addr[1:0] == 2'b00);

  // A flush hides the queue contents for that cycle, so nothing is popped.
  assign w_avail = !w_empty && !flush;
  assign w_done  = (r_state == S_WAIT) && (dmem_ready || (r_cnt == CNT_W'(TIMEOUT - 1)));
  assign w_issue = w_avail && w_head_aligned && ((r_state == S_IDLE) || w_done);
  assign w_pop   = w_avail && ((r_state == S_IDLE) || (w_done && w_head_aligned));

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_q_we[w_wr_idx]    <= req_we;
      r_q_addr[w_wr_idx]  <= req_addr;
      r_q_wdata[w_wr_idx] <= req_wdata;
      r_q_tag[w_wr_idx]   <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push && !flush) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (flush)            r_rd_ptr <= r_wr_ptr;
      else if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_suppress      <= 1'b0;
      r_cur_tag       <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_tag      <= '0;
      r_resp_rdata    <= '0;
      r_resp_is_store <= 1'b0;
      r_resp_err      <= 1'b0;
      r_dmem_req      <= 1'b0;
      r_dmem_we       <= 1'b0;
      r_dmem_addr     <= '0;
      r_dmem_wdata    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_dmem_req   <= w_issue;
      if (w_issue) begin
        r_dmem_we    <= w_head_we;
        r_dmem_addr  <= {w_head_addr[ADDR_W-1:2], 2'b00};
        r_dmem_wdata <= w_head_wdata;
        r_cur_tag    <= w_head_tag;
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_ISSUE;
            r_suppress <= 1'b0;
          end else if (w_avail) begin
            r_resp_valid    <= 1'b1;
            r_resp_tag      <= w_head_tag;
            r_resp_is_store <= w_head_we;
            r_resp_err      <= 1'b1;
            r_resp_rdata    <= '0;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
          if (flush) r_suppress <= 1'b1;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (flush) r_suppress <= 1'b1;
          if (w_done) begin
            // A flushed op still finishes on the bus but reports nothing.
            if (!r_suppress && !flush) begin
              r_resp_valid    <= 1'b1;
              r_resp_tag      <= r_cur_tag;
              r_resp_is_store <= r_dmem_we;
              r_resp_err      <= !dmem_ready;
              r_resp_rdata    <= (dmem_ready && !r_dmem_we) ? dmem_rdata : '0;
            end
            if (w_issue) begin
              r_state    <= S_ISSUE;
              r_suppress <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = !w_full;
  assign busy          = !w_empty || (r_state != S_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_tag      = r_resp_tag;
  assign resp_rdata    = r_resp_rdata;
  assign resp_is_store = r_resp_is_store;
  assign resp_err      = r_resp_err;
  assign dmem_req      = r_dmem_req;
  assign dmem_we       = r_dmem_we;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_wdata    = r_dmem_wdata;
endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: a delay-programmable word-memory responder
// plus a monitor that timestamps every bus request and every response.
module tb_lsu_dmem_master;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we, flush, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  req_tag, resp_tag;
  logic        resp_valid, resp_is_store, resp_err, dmem_req, dmem_we, dmem_ready;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  lsu_dmem_master #(.ADDR_W(32), .DATA_W(32), .TAG_W(4), .QDEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_rdata(resp_rdata),
    .resp_is_store(resp_is_store), .resp_err(resp_err), .flush(flush), .busy(busy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h12345678 : (32'hA5A50000 | 32'(i));
  endfunction

  // Responder: answers resp_lat cycles after seeing dmem_req (when enabled).
  logic [31:0] data_mem [0:63];
  int          resp_lat = 1;
  bit          resp_en = 1'b1;
  initial begin
    int          cd;
    logic        lw;
    logic [31:0] la, lwd;
    cd = 0; lw = 1'b0; la = '0; lwd = '0;
    for (int i = 0; i < 64; i++) data_mem[i] = init_word(i);
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dmem_ready = 1'b1;
          if (lw) begin
            data_mem[la[7:2]] = lwd;
            dmem_rdata = 32'hBADBAD00;
          end else begin
            dmem_rdata = data_mem[la[7:2]];
          end
        end
      end
      if (dmem_req && resp_en) begin
        cd = resp_lat; lw = dmem_we; la = dmem_addr; lwd = dmem_wdata;
      end
    end
  end

  typedef struct {
    int          c;
    logic [3:0]  tag;
    logic [31:0] rdata;
    logic        st;
    logic        err;
  } resp_t;
  resp_t resp_q[$];
  int    req_c_q[$];
  logic  req_we_q[$];

  always @(negedge clk) begin
    if (dmem_req) begin
      req_c_q.push_back(cyc);
      req_we_q.push_back(dmem_we);
    end
    if (resp_valid) resp_q.push_back('{cyc, resp_tag, resp_rdata, resp_is_store, resp_err});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input int idx, input int exp_c,
                          input logic [3:0] etag, input logic [31:0] edata,
                          input logic est, input logic eerr);
    if (idx < resp_q.size()) begin
      if (exp_c >= 0) chk({tag, "_cycle"}, 64'(resp_q[idx].c), 64'(exp_c));
      chk({tag, "_tag"},   64'(resp_q[idx].tag),   64'(etag));
      chk({tag, "_rdata"}, 64'(resp_q[idx].rdata), 64'(edata));
      chk({tag, "_store"}, 64'(resp_q[idx].st),    64'(est));
      chk({tag, "_err"},   64'(resp_q[idx].err),   64'(eerr));
    end else begin
      chk({tag, "_present"}, 64'(resp_q.size()), 64'(idx + 1));
    end
  endtask

  // Must be called on a negedge; returns on the following negedge.
  task automatic enq(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] t, output bit acc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_tag = t;
    acc = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int T, r0, q0, nacc;
    bit acc;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_tag = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_dmem_req",   64'(dmem_req), 0);
    chk("rst_dmem_we",    64'(dmem_we), 0);
    chk("rst_dmem_addr",  64'(dmem_addr), 0);
    chk("rst_dmem_wdata", 64'(dmem_wdata), 0);
    chk("rst_req_ready",  64'(req_ready), 1);
    chk("rst_busy",       64'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single load: req at T+2, response at T+4.
    T = cyc; r0 = resp_q.size(); q0 = req_c_q.size();
    enq(1'b0, 32'h0, 32'h0, 4'd3, acc);
    chk("ld_accept", 64'(acc), 1);
    wait_idle("ld", 40);
    chk("ld_nreq", 64'(req_c_q.size()), 64'(q0 + 1));
    if (req_c_q.size() > q0) chk("ld_req_cycle", 64'(req_c_q[q0]), 64'(T + 2));
    chk("ld_nresp", 64'(resp_q.size()), 64'(r0 + 1));
    chk_resp("ld", r0, T + 4, 4'd3, 32'h12345678, 1'b0, 1'b0);

    // Store then load of the same word, back to back.
    T = cyc; r0 = resp_q.size(); q0 = req_c_q.size();
    enq(1'b1, 32'h4, 32'hDEADBEEF, 4'd1, acc);
    enq(1'b0, 32'h4, 32'h0, 4'd2, acc);
    wait_idle("stld", 40);
    chk("stld_nreq", 64'(req_c_q.size()), 64'(q0 + 2));
    if (req_c_q.size() > q0 + 1) begin
      chk("stld_we0", 64'(req_we_q[q0]), 1);
      chk("stld_we1", 64'(req_we_q[q0 + 1]), 0);
      chk("stld_req_gap", 64'(req_c_q[q0 + 1] - req_c_q[q0]), 2);
    end
    chk_resp("stld_st", r0,     T + 4, 4'd1, 32'h0,        1'b1, 1'b0);
    chk_resp("stld_ld", r0 + 1, T + 6, 4'd2, 32'hDEADBEEF, 1'b0, 1'b0);

    // Fill the FIFO behind a slow responder.
    resp_lat = 6;
    r0 = resp_q.size(); q0 = req_c_q.size(); nacc = 0;
    for (int i = 0; i < 5; i++) begin
      enq(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'(5 + i), acc);
      nacc += int'(acc);
    end
    chk("full_accepted", 64'(nacc), 5);
    chk("full_ready", 64'(req_ready), 0);
    chk("full_nreq_early", 64'(req_c_q.size()), 64'(q0 + 1));
    wait_idle("full", 100);
    chk("full_nresp", 64'(resp_q.size()), 64'(r0 + 5));
    for (int i = 0; i < 5; i++)
      chk_resp($sformatf("full%0d", i), r0 + i, -1, 4'(5 + i), init_word(16 + i), 1'b0, 1'b0);

    // Misaligned load: no bus access, error response one cycle after pop.
    resp_lat = 1;
    T = cyc; r0 = resp_q.size(); q0 = req_c_q.size();
    enq(1'b0, 32'h6, 32'h0, 4'd4, acc);
    repeat (3) @(negedge clk);
    chk("mis_nreq", 64'(req_c_q.size()), 64'(q0));
    chk("mis_busy", 64'(busy), 0);
    chk_resp("mis", r0, T + 2, 4'd4, 32'h0, 1'b0, 1'b1);

    // Timeout after 8 WAIT cycles; the queued op then issues normally.
    resp_en = 1'b0;
    @(negedge clk);
    T = cyc; r0 = resp_q.size(); q0 = req_c_q.size();
    enq(1'b0, 32'h8, 32'h0, 4'd10, acc);
    enq(1'b0, 32'hC, 32'h0, 4'd11, acc);
    repeat (3) @(negedge clk);
    resp_en = 1'b1;
    wait_idle("to", 60);
    chk("to_nreq", 64'(req_c_q.size()), 64'(q0 + 2));
    if (req_c_q.size() > q0 + 1) begin
      chk("to_req0_cycle", 64'(req_c_q[q0]), 64'(T + 2));
      chk("to_req1_cycle", 64'(req_c_q[q0 + 1]), 64'(T + 11));
    end
    chk_resp("to_err", r0,     T + 11, 4'd10, 32'h0,        1'b0, 1'b1);
    chk_resp("to_ok",  r0 + 1, T + 13, 4'd11, init_word(3), 1'b0, 1'b0);

    // Flush while the first of three ops is in WAIT.
    resp_lat = 4;
    r0 = resp_q.size(); q0 = req_c_q.size();
    enq(1'b0, 32'h50, 32'h0, 4'd12, acc);
    enq(1'b0, 32'h54, 32'h0, 4'd13, acc);
    enq(1'b0, 32'h58, 32'h0, 4'd14, acc);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy_inflight", 64'(busy), 1);
    wait_idle("fl", 40);
    chk("fl_nreq", 64'(req_c_q.size()), 64'(q0 + 1));
    chk("fl_nresp", 64'(resp_q.size()), 64'(r0));
    chk("fl_ready", 64'(req_ready), 1);

    // Reset during WAIT of a store; the late dmem_ready must be ignored.
    resp_lat = 3;
    r0 = resp_q.size(); q0 = req_c_q.size();
    enq(1'b1, 32'h20, 32'hCAFEF00D, 4'd15, acc);
    @(negedge clk);
    chk("rw_req",  64'(dmem_req), 1);
    chk("rw_addr", 64'(dmem_addr), 64'h20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_resp_valid", 64'(resp_valid), 0);
    chk("rw_dmem_req",   64'(dmem_req), 0);
    chk("rw_dmem_we",    64'(dmem_we), 0);
    chk("rw_dmem_addr",  64'(dmem_addr), 0);
    chk("rw_dmem_wdata", 64'(dmem_wdata), 0);
    chk("rw_busy",       64'(busy), 0);
    chk("rw_ready",      64'(req_ready), 1);
    repeat (5) @(negedge clk);
    chk("rw_nresp", 64'(resp_q.size()), 64'(r0));
    chk("rw_nreq",  64'(req_c_q.size()), 64'(q0 + 1));
    chk("rw_busy_after", 64'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
